// File: rtl/harmonic_mixer.sv
// rtl/harmonic_mixer.sv - additive harmonic mixer: four LUT harmonics, one shared multiplier, ~1/100 scale, saturation
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   sample_tick    one-cycle pulse at the audio sample rate
//   note_en        note active; low clears the phase and yields zero samples
//   tuning_word    phase increment applied on every tick
//   harm_word      {w1,w2,w3,w4 (7b percent each), neg1,neg2,neg3,neg4}
//   sine_addr      address to the shared synchronous sine LUT
//   sine_data      signed LUT data, one cycle after sine_addr
//   sample_out     registered signed mixed sample
//   sample_valid   one-cycle pulse when sample_out updates
//   busy           high while a sample is being computed
//   overrun        sticky flag: a tick arrived while busy

module harmonic_mixer #(
  parameter int SAMPLE_W = 16,
  parameter int PHASE_W  = 24,
  parameter int LUT_AW   = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_tick,
  input  logic                       note_en,
  input  logic [PHASE_W-1:0]         tuning_word,
  input  logic [31:0]                harm_word,
  output logic [LUT_AW-1:0]          sine_addr,
  input  logic signed [SAMPLE_W-1:0] sine_data,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int ACC_W    = SAMPLE_W + 9;
  localparam int PROD_W   = 32;
  localparam int SCALE_SH = 12;
  localparam int SAT_MAX  = (1 << (SAMPLE_W - 1)) - 1;
  localparam int SAT_MIN  = -(1 << (SAMPLE_W - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SCALE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 idx_q, idx_d;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic [LUT_AW-1:0]          p_q, p_d;
  logic [3:0][6:0]            w_q, w_d;
  logic [3:0]                 neg_q, neg_d;
  logic                       en_q, en_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [LUT_AW-1:0]          sine_addr_q, sine_addr_d;
  logic signed [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       overrun_q, overrun_d;

  logic [1:0]                 hsel;
  logic signed [ACC_W-1:0]    mul_a;
  logic signed [7:0]          mul_b;
  logic signed [PROD_W-1:0]   prod;
  logic [ACC_W-1:0]           prod_lo;
  logic [ACC_W-1:0]           term;
  logic signed [PROD_W-1:0]   y;
  logic signed [SAMPLE_W-1:0] y_sat;
  logic [LUT_AW-1:0]          p_snap;

  function automatic logic [6:0] clamp_w(input logic [6:0] w);
    return (w > 7'd100) ? 7'd100 : w;
  endfunction

  assign p_snap = phase_q[PHASE_W-1 -: LUT_AW];

  // Single multiplier shared between the harmonic products (RUN) and the
  // x41 scaling step (SCALE). In RUN, idx i accumulates harmonic i, whose
  // LUT word was addressed during idx i-1, so the weight select is idx-1.
  always_comb begin
    hsel = idx_q[1:0] - 2'd1;
    if (state_q == S_SCALE) begin
      mul_a = acc_q;
      mul_b = 8'sd41;
    end else begin
      mul_a = {{(ACC_W - SAMPLE_W){sine_data[SAMPLE_W-1]}}, sine_data};
      mul_b = {1'b0, w_q[hsel]};
    end
    prod    = {{(PROD_W - ACC_W){mul_a[ACC_W-1]}}, mul_a} *
              {{(PROD_W - 8){mul_b[7]}}, mul_b};
    prod_lo = prod[ACC_W-1:0];
    term    = neg_q[hsel] ? -prod_lo : prod_lo;

    // 41/4096 ~= 1/100; arithmetic shift truncates toward -inf.
    y = prod >>> SCALE_SH;
    if (y > SAT_MAX) begin
      y_sat = SAT_MAX[SAMPLE_W-1:0];
    end else if (y < SAT_MIN) begin
      y_sat = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      y_sat = y[SAMPLE_W-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    phase_d        = phase_q;
    p_d            = p_q;
    w_d            = w_q;
    neg_d          = neg_q;
    en_d           = en_q;
    acc_d          = acc_q;
    sine_addr_d    = sine_addr_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q;

    // Phase keeps running on every tick, even while a sample is in flight.
    if (sample_tick) begin
      phase_d = note_en ? (phase_q + tuning_word) : '0;
      if (state_q != S_IDLE) begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          state_d     = S_RUN;
          idx_d       = 3'd0;
          p_d         = p_snap;
          w_d[0]      = clamp_w(harm_word[31:25]);
          w_d[1]      = clamp_w(harm_word[24:18]);
          w_d[2]      = clamp_w(harm_word[17:11]);
          w_d[3]      = clamp_w(harm_word[10:4]);
          neg_d       = {harm_word[0], harm_word[1], harm_word[2], harm_word[3]};
          en_d        = note_en;
          acc_d       = '0;
          sine_addr_d = p_snap;
        end
      end

      S_RUN: begin
        if (idx_q != 3'd0) begin
          acc_d = acc_q + (en_q ? term : '0);
        end
        // Next harmonic address, formed by shift/add rather than a multiply.
        case (idx_q)
          3'd0:    sine_addr_d = p_q << 1;
          3'd1:    sine_addr_d = p_q + (p_q << 1);
          3'd2:    sine_addr_d = p_q << 2;
          default: sine_addr_d = sine_addr_q;
        endcase
        if (idx_q == 3'd4) begin
          state_d = S_SCALE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      S_SCALE: begin
        sample_out_d   = y_sat;
        sample_valid_d = 1'b1;
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      phase_q        <= '0;
      p_q            <= '0;
      w_q            <= '0;
      neg_q          <= '0;
      en_q           <= 1'b0;
      acc_q          <= '0;
      sine_addr_q    <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      phase_q        <= phase_d;
      p_q            <= p_d;
      w_q            <= w_d;
      neg_q          <= neg_d;
      en_q           <= en_d;
      acc_q          <= acc_d;
      sine_addr_q    <= sine_addr_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sine_addr    = sine_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun      = overrun_q;

endmodule
